// File: rtl/inverse_pkg.sv
// Shared definitions for the Gauss-Jordan inverse datapath.
// Holds the default geometry of the multiplier bank, the float word type
// that the multipliers use, and the state encoding of the multiplier
// sequencer.
package inverse_pkg;

    localparam int WIDTH    = 27;  // float word width used by the multipliers
    localparam int LANES    = 15;  // number of external multipliers
    localparam int DEPTH    = 36;  // maximum products per batch (6x6)
    localparam int MULT_LAT = 5;   // multiplier pipeline latency in cycles

    typedef logic [WIDTH-1:0] word_t;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        DRAIN,
        FIN
    } state_t;

endpackage

// File: rtl/mult_tag_pipe.sv
// Tag shift register that runs alongside the external multipliers.
// Every cycle the sequencer pushes {valid, group, lane mask}. The tag comes
// out MULT_LAT enabled cycles later, exactly when the multipliers present
// the matching products.
// Ports:
//   clk, rst   clock, synchronous active-high reset (clears all tags)
//   en         advance enable; with en=0 the pipe holds
//   in_valid   a group is being issued this cycle
//   in_group   index of the issued group
//   in_mask    lanes of the issued group that carry real operands
//   out_*      the tag that is retiring this cycle
module mult_tag_pipe #(
    parameter int GRP_W    = 2,
    parameter int LANES    = 15,
    parameter int MULT_LAT = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             in_valid,
    input  logic [GRP_W-1:0] in_group,
    input  logic [LANES-1:0] in_mask,
    output logic             out_valid,
    output logic [GRP_W-1:0] out_group,
    output logic [LANES-1:0] out_mask
);

    logic             vld_p [MULT_LAT];
    logic [GRP_W-1:0] grp_p [MULT_LAT];
    logic [LANES-1:0] msk_p [MULT_LAT];

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int k = 0; k < MULT_LAT; k++) begin
                vld_p[k] <= 1'b0;
                grp_p[k] <= '0;
                msk_p[k] <= '0;
            end
        end else if (en) begin
            vld_p[0] <= in_valid;
            grp_p[0] <= in_group;
            msk_p[0] <= in_mask;
            for (int k = 1; k < MULT_LAT; k++) begin
                vld_p[k] <= vld_p[k-1];
                grp_p[k] <= grp_p[k-1];
                msk_p[k] <= msk_p[k-1];
            end
        end
    end

    assign out_valid = vld_p[MULT_LAT-1];
    assign out_group = grp_p[MULT_LAT-1];
    assign out_mask  = msk_p[MULT_LAT-1];

endmodule

// File: rtl/array_mult_sched.sv
// Multiplier-bank sequencer for the Gauss-Jordan inverse.
// Shares LANES external multipliers across a batch of up to DEPTH operand
// pairs. The batch is issued LANES products per cycle. The products are
// collected MULT_LAT cycles later, and a one-cycle done pulse follows once
// the last group has been captured.
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   en                  global enable (also the multipliers' enable)
//   start               begin a batch (accepted only in IDLE)
//   mode                0: a[i]*b[i], 1: a[0]*b[i] (row scale)
//   num_ops             products in the batch, clamped to DEPTH
//   op_a, op_b          operand arrays, latched at start
//   array_mult_dataa/b  operands to the multiplier bank
//   array_mult_result   products from the multiplier bank
//   results             registered products of the current batch
//   busy                batch in flight
//   done                one-cycle pulse, results complete
module array_mult_sched
    import inverse_pkg::*;
#(
    parameter int WIDTH    = inverse_pkg::WIDTH,
    parameter int LANES    = inverse_pkg::LANES,
    parameter int DEPTH    = inverse_pkg::DEPTH,
    parameter int MULT_LAT = inverse_pkg::MULT_LAT,
    parameter int CNT_W    = $clog2(DEPTH + 1)
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   en,
    input  logic                   start,
    input  logic                   mode,
    input  logic [CNT_W-1:0]       num_ops,
    input  logic [DEPTH*WIDTH-1:0] op_a,
    input  logic [DEPTH*WIDTH-1:0] op_b,
    output logic [LANES*WIDTH-1:0] array_mult_dataa,
    output logic [LANES*WIDTH-1:0] array_mult_datab,
    input  logic [LANES*WIDTH-1:0] array_mult_result,
    output logic [DEPTH*WIDTH-1:0] results,
    output logic                   busy,
    output logic                   done
);

    localparam int MAX_G = (DEPTH + LANES - 1) / LANES;
    localparam int GRP_W = (MAX_G > 1) ? $clog2(MAX_G) : 1;
    // Wide enough for (g+1)*LANES with g at its maximum.
    localparam int IDX_W = $clog2(MAX_G * LANES + LANES + 1);

    state_t           state;
    logic [GRP_W-1:0] g;
    logic [CNT_W-1:0] n_lat;
    logic [CNT_W-1:0] n_req;
    logic [WIDTH-1:0] a_lat [DEPTH];
    logic [WIDTH-1:0] b_lat [DEPTH];
    logic [DEPTH-1:0] vld_lat;
    logic [LANES-1:0] issue_mask;
    logic             last_grp;

    logic             ret_valid;
    logic [GRP_W-1:0] ret_group;
    logic [LANES-1:0] ret_mask;

    assign n_req = (num_ops > CNT_W'(DEPTH)) ? CNT_W'(DEPTH) : num_ops;

    // The current group is the last one once its end index reaches n.
    assign last_grp = ((IDX_W'(g) + IDX_W'(1)) * IDX_W'(LANES)) >= IDX_W'(n_lat);

    // Lane l of group g carries entry g*LANES+l. Entries past n were latched
    // as zero, so the lanes they map to already see 0/0 here.
    always_comb begin
        array_mult_dataa = '0;
        array_mult_datab = '0;
        issue_mask       = '0;
        if (state == ISSUE) begin
            for (int j = 0; j < DEPTH; j++) begin
                if (g == GRP_W'(j / LANES)) begin
                    array_mult_dataa[(j % LANES)*WIDTH +: WIDTH] = a_lat[j];
                    array_mult_datab[(j % LANES)*WIDTH +: WIDTH] = b_lat[j];
                    issue_mask[j % LANES]                        = vld_lat[j];
                end
            end
        end
    end

    mult_tag_pipe #(
        .GRP_W    (GRP_W),
        .LANES    (LANES),
        .MULT_LAT (MULT_LAT)
    ) u_tag_pipe (
        .clk       (clk),
        .rst       (rst),
        .en        (en),
        .in_valid  (state == ISSUE),
        .in_group  (g),
        .in_mask   (issue_mask),
        .out_valid (ret_valid),
        .out_group (ret_group),
        .out_mask  (ret_mask)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            g       <= '0;
            n_lat   <= '0;
            vld_lat <= '0;
            results <= '0;
            busy    <= 1'b0;
            done    <= 1'b0;
            for (int j = 0; j < DEPTH; j++) begin
                a_lat[j] <= '0;
                b_lat[j] <= '0;
            end
        end else if (en) begin
            case (state)
                IDLE: begin
                    if (start) begin
                        // Broadcast mode is resolved here, so issue never needs mode.
                        for (int j = 0; j < DEPTH; j++) begin
                            if (j < int'(n_req)) begin
                                a_lat[j]   <= mode ? op_a[0 +: WIDTH] : op_a[j*WIDTH +: WIDTH];
                                b_lat[j]   <= op_b[j*WIDTH +: WIDTH];
                                vld_lat[j] <= 1'b1;
                            end else begin
                                a_lat[j]   <= '0;
                                b_lat[j]   <= '0;
                                vld_lat[j] <= 1'b0;
                            end
                        end
                        n_lat   <= n_req;
                        g       <= '0;
                        results <= '0;
                        if (n_req == '0) begin
                            state <= FIN;
                            done  <= 1'b1;
                        end else begin
                            state <= ISSUE;
                            busy  <= 1'b1;
                        end
                    end
                end
                ISSUE: begin
                    if (last_grp) begin
                        state <= DRAIN;
                    end else begin
                        g <= g + GRP_W'(1);
                    end
                end
                DRAIN: begin
                    // g still holds the last issued group; groups retire in order.
                    if (ret_valid && ret_group == g) begin
                        state <= FIN;
                        done  <= 1'b1;
                        busy  <= 1'b0;
                    end
                end
                FIN: begin
                    state <= IDLE;
                    done  <= 1'b0;
                end
                default: state <= IDLE;
            endcase

            // Retirement is independent of issue and can overlap ISSUE/DRAIN.
            for (int j = 0; j < DEPTH; j++) begin
                if (ret_valid && ret_group == GRP_W'(j / LANES) && ret_mask[j % LANES]) begin
                    results[j*WIDTH +: WIDTH] <= array_mult_result[(j % LANES)*WIDTH +: WIDTH];
                end
            end
        end
    end

endmodule

// File: doc/array_mult_sched.md
Name: array_mult_sched

Overview:
- Parametrised sequencer that shares a bank of LANES external array multipliers across a batch of up to DEPTH operand pairs.
- Generalises the fixed 15-lane multiplier hookup of the 6x6 inverse top. It adds batching, latency tracking, a broadcast (row-scale) mode and a completion handshake.
- Sits between the Gauss-Jordan inverse controller and the multiplier bank. The controller loads operands and pulses start; the block pulses done with all products registered.
- Arithmetic-agnostic: it only routes words to the multipliers and collects the results.

Parameters:
- WIDTH, 27, word width (float format used by the multipliers).
- LANES, 15, number of external multipliers.
- DEPTH, 36, maximum products per batch (N*N for N=6).
- MULT_LAT, 5, multiplier pipeline latency in cycles (>=1).
- CNT_W, $clog2(DEPTH+1), width of num_ops.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous active-high reset.
- en  in  1  global clock enable. Also drives the multipliers' enable.
- start  in  1  begin batch. Sampled only in IDLE with en=1.
- mode  in  1  0 = elementwise a[i]*b[i]; 1 = broadcast a[0]*b[i].
- num_ops  in  CNT_W  products in batch. Values >DEPTH are clamped to DEPTH.
- op_a  in  DEPTH*WIDTH  operand A array, latched at start.
- op_b  in  DEPTH*WIDTH  operand B array, latched at start.
- array_mult_dataa  out  LANES*WIDTH  to multipliers.
- array_mult_datab  out  LANES*WIDTH  to multipliers.
- array_mult_result  in  LANES*WIDTH  from multipliers, MULT_LAT cycles after issue.
- results  out  DEPTH*WIDTH  registered products.
- busy  out  1  high from the cycle after start until done.
- done  out  1  one-cycle pulse, results valid.

Behaviour:
- Reset values: all outputs are 0, state is IDLE, the operand latches and tag pipe are cleared. Reset mid-batch aborts the batch and does not emit done.
- en=0 freezes every register: state, counters, tag pipe, results. Outputs hold their values.
- States:
  - IDLE: on start&en, latch op_a, op_b, mode and n=min(num_ops,DEPTH). Set G=ceil(n/LANES). Go to ISSUE, or to FIN if n=0. Clear results.
  - ISSUE: group counter g runs 0..G-1, one group per en cycle. Lane l receives index i=g*LANES+l.
    - If i<n: dataa = (mode ? A[0] : A[i]) and datab = B[i].
    - Otherwise the lane gets 0/0 and is masked invalid.
    - After g=G-1, go to DRAIN.
  - DRAIN: wait until the tag pipe reports the last group retired, then go to FIN.
  - FIN: done=1 for one cycle, then IDLE.
- Outside ISSUE, array_mult_dataa/datab are driven to 0.
- Tag pipe: MULT_LAT-deep shift of {valid, group index, lane mask}, advancing on en. When a tag exits, results[g*LANES+l] <= array_mult_result[l] for each set mask bit. Unmasked entries are untouched.
- Timing: start sampled at edge T.
  - Group g is driven during cycle T+1+g.
  - Its result is captured at the end of cycle T+1+g+MULT_LAT.
  - done is high during cycle T+2+(G-1)+MULT_LAT = T+1+G+MULT_LAT.
  - For n=0, done is high during T+1.
- busy is high from T+1 through the cycle before done, and low during done. start is ignored while busy or during done.
- DRAIN and the last ISSUE cycle may overlap tag retirement. Retirement and issue in the same cycle are independent.

Decomposition:
- inverse_pkg: WIDTH, LANES, DEPTH, MULT_LAT defaults; typedef word_t (logic [WIDTH-1:0]); state enum {IDLE, ISSUE, DRAIN, FIN}.
- Sub-module mult_tag_pipe: parametrised MULT_LAT shift register of {valid, group, lane mask} with enable. It outputs the retiring tag.

Test Plan:
- Bench multiplier model: MULT_LAT-stage delay of f(a,b)=a+b mod 2^WIDTH.
- Elementwise full batch: n=36, A[i]=i, B[i]=100+i, start at T → three issue cycles T+1..T+3; done only during T+9; results[i]=100+2i; busy T+1..T+8.
- Broadcast partial batch: mode=1, n=7, A[0]=5, B[i]=i → one issue cycle with lanes 7..14 driven 0; results[0..6]=5+i; results[7..35]=0; done at T+7.
- n=0 and clamp: num_ops=0 → done at T+1, no nonzero dataa; num_ops=50 → treated as 36, done at T+9.
- Stall: n=20, en deasserted for 3 cycles mid-ISSUE → no register changes while en=0; done at T+8+3; results are correct.
- Reset and ignored start: rst at T+4 of an n=36 batch → no done, outputs 0, IDLE. A new start then completes normally. start pulsed while busy → no effect on the running batch.
